// File: rtl/isp_pkg.sv
// Shared constants, FSM state type and small helpers for the ISP exposure engine.
package isp_pkg;

  localparam logic [1:0] RATIO_QUARTER = 2'd0;
  localparam logic [1:0] RATIO_HALF    = 2'd1;
  localparam logic [1:0] RATIO_UNITY   = 2'd2;
  localparam logic [1:0] RATIO_DOUBLE  = 2'd3;

  localparam int unsigned         AXI_ID_W       = 4;
  localparam logic [AXI_ID_W-1:0] AXI_ID_RD      = 4'd0;
  localparam logic [AXI_ID_W-1:0] AXI_ID_WR      = 4'd1;
  localparam logic [1:0]          AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_ADDR,
    S_DATA,
    S_WRESP,
    S_DONE
  } state_t;

  function automatic int unsigned avg_shift(input int unsigned ch_beats, input int unsigned lanes);
    return $clog2(ch_beats * lanes);
  endfunction

  function automatic logic [2:0] axi_size(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/isp_beat_fifo.sv
// Synchronous beat FIFO between the AXI read and write channels.
module isp_beat_fifo #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/isp_exposure_engine.sv
// Auto-exposure engine: reads an R/G/B picture over AXI4, scales it, writes it back in place
// and reports the weighted luminance average; all-zero pictures are cached per picture index.
module isp_exposure_engine
  import isp_pkg::*;
#(
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_PIC    = 16,
  parameter int unsigned CH_BEATS   = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h10000,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PIC_W     = $clog2(NUM_PIC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [PIC_W-1:0]    in_pic_no,
  input  logic [1:0]          in_ratio_mode,
  output logic                busy,
  output logic                out_valid,
  output logic [PIX_W-1:0]    out_data,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_DW-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_DW-1:0]   wdata,
  output logic [AXI_DW/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int unsigned LANES     = AXI_DW / PIX_W;
  localparam int unsigned BEATS     = 3 * CH_BEATS;
  localparam int unsigned BEAT_W    = $clog2(BEATS);
  localparam int unsigned ACC_W     = PIX_W + $clog2(BEATS * LANES);
  localparam int unsigned SUM_W     = PIX_W + $clog2(LANES);
  localparam int unsigned AVG_SHIFT = avg_shift(CH_BEATS, LANES);
  localparam int unsigned PIC_BYTES = BEATS * AXI_DW / 8;

  state_t              state;
  state_t              state_nx;
  logic [PIC_W-1:0]    pic;
  logic [1:0]          ratio;
  logic                ar_done;
  logic                aw_done;
  logic [BEAT_W-1:0]   rd_cnt;
  logic [BEAT_W-1:0]   wr_cnt;
  logic [ACC_W-1:0]    acc;
  logic                any_nz;
  logic [NUM_PIC-1:0]  zero_flag;

  logic                bypass;
  logic                is_green;
  logic                r_fire;
  logic                w_fire;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AXI_DW-1:0]   scaled;
  logic [SUM_W-1:0]    beat_sum;
  logic [PIX_W-1:0]    pix;
  logic [PIX_W-1:0]    spix;
  logic                unused_resp;

  assign bypass      = (ratio == RATIO_UNITY);
  assign is_green    = (rd_cnt >= BEAT_W'(CH_BEATS)) && (rd_cnt < BEAT_W'(2 * CH_BEATS));
  assign r_fire      = rvalid && rready;
  assign w_fire      = wvalid && wready;
  assign unused_resp = ^{rresp, bresp};

  assign arid    = AXI_ID_RD;
  assign araddr  = BASE_ADDR + 32'(pic) * 32'(PIC_BYTES);
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = axi_size(AXI_DW);
  assign arburst = AXI_BURST_INCR;
  assign awid    = AXI_ID_WR;
  assign awaddr  = araddr;
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = axi_size(AXI_DW);
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = '1;
  assign wlast   = (wr_cnt == BEAT_W'(BEATS - 1));

  // Per-lane scaling, then R/B weighted 1/4 and G weighted 1/2 into one beat sum.
  always_comb begin
    scaled   = '0;
    beat_sum = '0;
    pix      = '0;
    spix     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pix = rdata[i*PIX_W +: PIX_W];
      unique case (ratio)
        RATIO_QUARTER: spix = pix >> 2;
        RATIO_HALF:    spix = pix >> 1;
        RATIO_UNITY:   spix = pix;
        RATIO_DOUBLE:  spix = pix[PIX_W-1] ? '1 : (pix << 1);
      endcase
      scaled[i*PIX_W +: PIX_W] = spix;
      beat_sum = beat_sum + SUM_W'(is_green ? (spix >> 1) : (spix >> 2));
    end
  end

  isp_beat_fifo #(
    .W     (AXI_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_fire && !bypass),
    .din   (scaled),
    .pop   (w_fire),
    .dout  (wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    rready    = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_CHK;
      S_CHK:  state_nx = zero_flag[pic] ? S_DONE : S_ADDR;
      S_ADDR: begin
        arvalid = !ar_done;
        awvalid = !bypass && !aw_done;
        if ((ar_done || arready) && (bypass || aw_done || awready)) state_nx = S_DATA;
      end
      S_DATA: begin
        if (bypass) begin
          rready = 1'b1;
          if (rvalid && rlast) state_nx = S_DONE;
        end else begin
          rready = !fifo_full;
          wvalid = !fifo_empty;
          if (!fifo_empty && wready && wlast) state_nx = S_WRESP;
        end
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_data  = PIX_W'(acc >> AVG_SHIFT);
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pic       <= '0;
      ratio     <= '0;
      ar_done   <= 1'b0;
      aw_done   <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      acc       <= '0;
      any_nz    <= 1'b0;
      zero_flag <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && in_valid) begin
        pic     <= in_pic_no;
        ratio   <= in_ratio_mode;
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        acc     <= '0;
        any_nz  <= 1'b0;
      end
      if (arvalid && arready) ar_done <= 1'b1;
      if (awvalid && awready) aw_done <= 1'b1;
      if (r_fire) begin
        acc    <= acc + ACC_W'(beat_sum);
        any_nz <= any_nz | (|scaled);
        rd_cnt <= (rd_cnt == BEAT_W'(BEATS - 1)) ? '0 : rd_cnt + 1'b1;
      end
      if (w_fire) wr_cnt <= wlast ? '0 : wr_cnt + 1'b1;
      // A cache hit arrives here with any_nz still clear, so its flag simply stays set.
      if (state == S_DONE && !any_nz) zero_flag[pic] <= 1'b1;
    end
  end

endmodule
